// File: rtl/pcs_pkg.sv
// Shared PCS receive-side definitions: sync header codes, BER monitor states
// and the default BER window length.
package pcs_pkg;

   localparam logic [1:0] SYNC_HDR_DATA = 2'b01;
   localparam logic [1:0] SYNC_HDR_CTRL = 2'b10;

   // 125 us at 322.265625 MHz
   localparam int unsigned BER_WINDOW_CYCLES_DEFAULT = 40283;

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_TEST   = 2'd1,
      ST_HI_BER = 2'd2
   } ber_state_t;

endpackage : pcs_pkg

// File: rtl/rx_ber_monitor.sv
// Receive-side PCS high-BER controller. Counts invalid sync headers over a
// fixed cycle-based window and raises o_hi_ber when a window hits BER_THRESH.
//
// Ports:
//   i_clk          PCS RX clock
//   i_reset_n      asynchronous active-low reset
//   i_hdr          sync header from block sync
//   i_hdr_valid    qualifier for i_hdr (low on gearbox stall cycles)
//   i_block_lock   block lock from the lock-state logic
//   i_ber_cnt_clr  management clear pulse for o_ber_count
//   o_hi_ber       high-BER status
//   o_ber_count    saturating invalid-header count
//   o_win_done     one-cycle pulse after each window terminal cycle
module rx_ber_monitor
   import pcs_pkg::*;
#(
   parameter int unsigned HDR_WIDTH     = 2,
   parameter int unsigned TIMER_CYCLES  = BER_WINDOW_CYCLES_DEFAULT,
   parameter int unsigned BER_THRESH    = 16,
   parameter int unsigned BER_CNT_WIDTH = 6
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   input  logic [HDR_WIDTH-1:0]     i_hdr,
   input  logic                     i_hdr_valid,
   input  logic                     i_block_lock,
   input  logic                     i_ber_cnt_clr,
   output logic                     o_hi_ber,
   output logic [BER_CNT_WIDTH-1:0] o_ber_count,
   output logic                     o_win_done
);

   localparam int unsigned TMR_W = (TIMER_CYCLES > 1) ? $clog2(TIMER_CYCLES) : 1;
   localparam int unsigned WIN_W = $clog2(BER_THRESH + 1);

   localparam logic [TMR_W-1:0]         TMR_LAST   = TMR_W'(TIMER_CYCLES - 1);
   localparam logic [WIN_W-1:0]         WIN_THRESH = WIN_W'(BER_THRESH);
   localparam logic [BER_CNT_WIDTH-1:0] CNT_MAX    = '1;

   ber_state_t               state_q, state_d;
   logic [TMR_W-1:0]         timer_q, timer_d;
   logic [WIN_W-1:0]         win_cnt_q, win_cnt_d;
   logic                     hi_ber_q, hi_ber_d;
   logic [BER_CNT_WIDTH-1:0] ber_cnt_q, ber_cnt_d;
   logic                     win_done_q, win_done_d;

   logic hdr_bad_c;
   logic timer_last_c;
   logic [WIN_W-1:0] win_inc_c;

   assign hdr_bad_c    = i_hdr_valid
                         && (i_hdr != HDR_WIDTH'(SYNC_HDR_DATA))
                         && (i_hdr != HDR_WIDTH'(SYNC_HDR_CTRL));
   assign timer_last_c = (timer_q == TMR_LAST);
   assign win_inc_c    = WIN_W'(win_cnt_q + 1'b1);

   // State and status registers
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= ST_INIT;
         timer_q    <= '0;
         win_cnt_q  <= '0;
         hi_ber_q   <= 1'b0;
         ber_cnt_q  <= '0;
         win_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         win_cnt_q  <= win_cnt_d;
         hi_ber_q   <= hi_ber_d;
         ber_cnt_q  <= ber_cnt_d;
         win_done_q <= win_done_d;
      end
   end

   // Next-state: window FSM, timer, window counter and management counter
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_last_c ? '0 : TMR_W'(timer_q + 1'b1);
      win_cnt_d  = win_cnt_q;
      hi_ber_d   = hi_ber_q;
      win_done_d = 1'b0;

      // Clear wins over a same-cycle header, which then counts on top of zero
      ber_cnt_d = i_ber_cnt_clr ? '0 : ber_cnt_q;
      if (hdr_bad_c && i_block_lock && (ber_cnt_d != CNT_MAX)) begin
         ber_cnt_d = BER_CNT_WIDTH'(ber_cnt_d + 1'b1);
      end

      if (!i_block_lock) begin
         state_d   = ST_INIT;
         timer_d   = '0;
         win_cnt_d = '0;
         hi_ber_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_INIT: begin
               state_d   = ST_TEST;
               timer_d   = '0;
               win_cnt_d = '0;
               hi_ber_d  = 1'b0;
            end
            ST_TEST: begin
               win_done_d = timer_last_c;
               // A header on the terminal cycle is judged before the window closes
               if (hdr_bad_c && (win_inc_c == WIN_THRESH)) begin
                  state_d   = ST_HI_BER;
                  win_cnt_d = WIN_THRESH;
                  hi_ber_d  = 1'b1;
               end else if (timer_last_c) begin
                  win_cnt_d = '0;
                  hi_ber_d  = 1'b0;
               end else if (hdr_bad_c) begin
                  win_cnt_d = win_inc_c;
               end
            end
            ST_HI_BER: begin
               if (timer_last_c) begin
                  state_d    = ST_TEST;
                  win_cnt_d  = '0;
                  win_done_d = 1'b1;
               end
            end
            default: begin
               state_d   = ST_INIT;
               timer_d   = '0;
               win_cnt_d = '0;
               hi_ber_d  = 1'b0;
            end
         endcase
      end
   end

   assign o_hi_ber    = hi_ber_q;
   assign o_ber_count = ber_cnt_q;
   assign o_win_done  = win_done_q;

   a_win_cnt_bound: assert property (@(posedge i_clk) disable iff (!i_reset_n)
      win_cnt_q <= WIN_THRESH);

   a_no_done_in_init: assert property (@(posedge i_clk) disable iff (!i_reset_n)
      !(win_done_q && (state_q == ST_INIT)));

endmodule : rx_ber_monitor

// File: tb/tb_rx_ber_monitor.sv
// Directed bench for rx_ber_monitor with a 64-cycle BER window.
module tb_rx_ber_monitor;
   import pcs_pkg::*;

   localparam int unsigned TC  = 64;
   localparam int unsigned BCW = 6;

   localparam logic [1:0] HB = 2'b11;
   localparam logic [1:0] HZ = 2'b00;
   localparam logic [1:0] HD = SYNC_HDR_DATA;
   localparam logic [1:0] HC = SYNC_HDR_CTRL;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [1:0]     hdr;
   logic           hdr_valid;
   logic           lock;
   logic           clr;
   logic           hi_ber;
   logic [BCW-1:0] ber_count;
   logic           win_done;

   int n_asserts = 0;
   int n_fail    = 0;
   int k;

   rx_ber_monitor #(
      .HDR_WIDTH    (2),
      .TIMER_CYCLES (TC),
      .BER_THRESH   (16),
      .BER_CNT_WIDTH(BCW)
   ) dut (
      .i_clk        (clk),
      .i_reset_n    (rst_n),
      .i_hdr        (hdr),
      .i_hdr_valid  (hdr_valid),
      .i_block_lock (lock),
      .i_ber_cnt_clr(clr),
      .o_hi_ber     (hi_ber),
      .o_ber_count  (ber_count),
      .o_win_done   (win_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d (k=%0d)", tag, obs, exp, k);
      end
   endtask

   task automatic cyc(input logic [1:0] h, input logic v, input logic l, input logic c);
      hdr       = h;
      hdr_valid = v;
      lock      = l;
      clr       = c;
      @(posedge clk);
      #1;
      k++;
   endtask

   initial begin
      rst_n     = 1'b0;
      hdr       = HD;
      hdr_valid = 1'b0;
      lock      = 1'b0;
      clr       = 1'b0;
      k         = 0;

      // Reset state
      #12;
      check("rst_hi_ber", 32'(hi_ber), 32'd0);
      check("rst_count", 32'(ber_count), 32'd0);
      check("rst_win_done", 32'(win_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Unlocked: invalid headers are ignored
      repeat (3) cyc(HB, 1'b1, 1'b0, 1'b0);
      check("unlocked_count", 32'(ber_count), 32'd0);
      check("unlocked_done", 32'(win_done), 32'd0);

      // Lock: first TEST cycle has timer 0
      cyc(HD, 1'b1, 1'b1, 1'b0);
      k = 0;

      // 1: clean traffic for 3 windows; stalled 2'b11 headers are not sampled
      for (int i = 1; i <= 192; i++) begin
         if (i % 5 == 0) cyc(HB, 1'b0, 1'b1, 1'b0);
         else            cyc((i % 2 != 0) ? HD : HC, 1'b1, 1'b1, 1'b0);
         check("t1_done", 32'(win_done), 32'(k % 64 == 0));
      end
      check("t1_hi_ber", 32'(hi_ber), 32'd0);
      check("t1_count", 32'(ber_count), 32'd0);

      // 2: 16 invalid headers at the start of a window
      for (int i = 0; i < 16; i++) begin
         cyc(HB, 1'b1, 1'b1, 1'b0);
         if (i == 14) check("t2_pre_hi_ber", 32'(hi_ber), 32'd0);
      end
      check("t2_hi_ber", 32'(hi_ber), 32'd1);
      check("t2_count", 32'(ber_count), 32'd16);

      // 4: clean traffic; hi_ber held to the end of the next full window
      for (int i = 209; i <= 320; i++) begin
         cyc((i % 2 != 0) ? HD : HC, 1'b1, 1'b1, 1'b0);
         check("t4_hi_ber", 32'(hi_ber), 32'(k < 320));
         check("t4_done", 32'(win_done), 32'(k % 64 == 0));
      end

      // 3: 15 invalid in each of two windows never trips
      cyc(HD, 1'b1, 1'b1, 1'b1);
      check("t3_clr", 32'(ber_count), 32'd0);
      for (int i = 322; i <= 448; i++) begin
         if ((i <= 336) || (i >= 385 && i <= 399)) cyc((i % 2 != 0) ? HB : HZ, 1'b1, 1'b1, 1'b0);
         else                                      cyc(HC, 1'b1, 1'b1, 1'b0);
         check("t3_hi_ber", 32'(hi_ber), 32'd0);
         check("t3_done", 32'(win_done), 32'(k % 64 == 0));
      end
      check("t3_count", 32'(ber_count), 32'd30);

      // 3b: the 16th invalid header lands on the terminal cycle
      for (int i = 449; i <= 512; i++) begin
         if ((i <= 463) || (i == 512)) cyc(HB, 1'b1, 1'b1, 1'b0);
         else                          cyc(HD, 1'b1, 1'b1, 1'b0);
         if (i == 511) check("t3b_pre_hi_ber", 32'(hi_ber), 32'd0);
      end
      check("t3b_hi_ber", 32'(hi_ber), 32'd1);
      check("t3b_done", 32'(win_done), 32'd1);
      check("t3b_count", 32'(ber_count), 32'd46);

      // 5: 10 invalid, drop lock, relock
      cyc(HD, 1'b1, 1'b1, 1'b1);
      check("t5_clr", 32'(ber_count), 32'd0);
      repeat (10) cyc(HB, 1'b1, 1'b1, 1'b0);
      check("t5_count10", 32'(ber_count), 32'd10);
      check("t5_hi_ber_held", 32'(hi_ber), 32'd1);
      cyc(HB, 1'b1, 1'b0, 1'b0);
      check("t5_unlock_hi_ber", 32'(hi_ber), 32'd0);
      check("t5_unlock_count", 32'(ber_count), 32'd10);
      check("t5_unlock_done", 32'(win_done), 32'd0);
      repeat (2) cyc(HZ, 1'b1, 1'b0, 1'b0);
      check("t5_init_count", 32'(ber_count), 32'd10);
      cyc(HD, 1'b1, 1'b1, 1'b0);
      k = 0;
      check("t5_relock_hi_ber", 32'(hi_ber), 32'd0);
      check("t5_relock_count", 32'(ber_count), 32'd10);

      // 5/6: fresh 16 needed; counter saturates at 63
      for (int i = 1; i <= 70; i++) begin
         cyc(HB, 1'b1, 1'b1, 1'b0);
         check("t6_hi_ber", 32'(hi_ber), 32'(k >= 16));
         check("t6_count", 32'(ber_count), (10 + k > 63) ? 32'd63 : 32'(10 + k));
         check("t6_done", 32'(win_done), 32'(k == 64));
      end

      // Clear together with an invalid header
      cyc(HB, 1'b1, 1'b1, 1'b1);
      check("t6_clr_inv", 32'(ber_count), 32'd1);
      repeat (9) cyc(HB, 1'b1, 1'b1, 1'b0);
      check("t6_count10", 32'(ber_count), 32'd10);
      check("t6_hi_ber_re", 32'(hi_ber), 32'd1);

      // Asynchronous reset while in high BER, away from a clock edge
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_hi_ber", 32'(hi_ber), 32'd0);
      check("arst_count", 32'(ber_count), 32'd0);
      check("arst_done", 32'(win_done), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule : tb_rx_ber_monitor

// File: doc/rx_ber_monitor.md
Name: rx_ber_monitor

Overview:
- Receive-side PCS high-bit-error-rate controller. It watches the sync headers produced by the RX block-sync/lock datapath and counts invalid headers over a fixed 125 us window.
- It asserts hi_ber when the count in one window reaches the threshold. The decoder uses hi_ber to force error blocks, and link status uses it to declare the link down.
- It sits beside the lock-state logic, between the RX gearbox and the decoder.

Parameters:
- HDR_WIDTH, 2, sync header width.
- TIMER_CYCLES, 40283, clock cycles per BER window (125 us at 322.265625 MHz). Benches use 64.
- BER_THRESH, 16, invalid headers per window that trigger hi_ber.
- BER_CNT_WIDTH, 6, width of the saturating management error counter.

Ports:
- i_clk  in  1  PCS RX clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_hdr  in  HDR_WIDTH  sync header from block sync.
- i_hdr_valid  in  1  i_hdr qualifier; may be low on gearbox stall cycles.
- i_block_lock  in  1  block lock from the lock-state logic.
- i_ber_cnt_clr  in  1  management clear pulse for o_ber_count.
- o_hi_ber  out  1  high-BER status, registered.
- o_ber_count  out  BER_CNT_WIDTH  saturating invalid-header count, registered.
- o_win_done  out  1  one-cycle pulse at each window terminal cycle, registered.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. On reset: state=ST_INIT, timer=0, win_cnt=0, o_hi_ber=0, o_ber_count=0, o_win_done=0.
- Invalid header: i_hdr_valid=1 and i_hdr is 2'b00 or 2'b11. Headers 2'b01 and 2'b10 are valid. Nothing is sampled while i_hdr_valid=0.
- The window timer counts clock cycles, not headers. Its terminal cycle is timer==TIMER_CYCLES-1. Width is $clog2(TIMER_CYCLES).
- ST_INIT:
  - timer=0, win_cnt=0, o_hi_ber=0.
  - Goes to ST_TEST on the cycle after i_block_lock=1. The timer starts at 0 in the first ST_TEST cycle.
- ST_TEST:
  - timer increments every cycle.
  - Each invalid header increments win_cnt.
  - If the increment makes win_cnt==BER_THRESH: go to ST_HI_BER and set o_hi_ber=1 the next cycle. The timer is not restarted.
  - Else, on the terminal cycle: timer=0, win_cnt=0, o_hi_ber=0 (good window), stay in ST_TEST.
- ST_HI_BER:
  - timer keeps running. Headers are not added to win_cnt.
  - On the terminal cycle: timer=0, win_cnt=0, go to ST_TEST. o_hi_ber stays 1.
  - o_hi_ber clears only at the end of a later full ST_TEST window with fewer than BER_THRESH invalid headers.
- Terminal cycle with an invalid header at the same time: the header belongs to the ending window and is counted first. If it reaches the threshold, the window goes to ST_HI_BER instead of being judged good.
- o_win_done pulses the cycle after each terminal cycle in ST_TEST or ST_HI_BER.
- i_block_lock=0 in any state: go to ST_INIT the next cycle. This has the highest priority. It clears timer, win_cnt and o_hi_ber, but does not clear o_ber_count.
- o_ber_count:
  - Increments by one on every invalid header sampled while i_block_lock=1, in any state. Saturates at 2^BER_CNT_WIDTH-1.
  - i_ber_cnt_clr loads 0. If a clear and an invalid header arrive in the same cycle, the result is 1.
- Latency: an invalid header sampled in cycle N appears in o_ber_count in cycle N+1. The threshold-crossing header sampled in cycle N gives o_hi_ber=1 in cycle N+1.
- Assertions: win_cnt never exceeds BER_THRESH; o_win_done is never high in ST_INIT.

Decomposition:
- Shared package pcs_pkg holds:
  - SYNC_HDR_DATA=2'b01 and SYNC_HDR_CTRL=2'b10;
  - enum ber_state_t {ST_INIT, ST_TEST, ST_HI_BER};
  - BER_WINDOW_CYCLES_DEFAULT.
- No sub-module is needed. The timer, window counter and FSM stay in one module.

Test Plan (TIMER_CYCLES=64):
1. Lock held, only 2'b01/2'b10 headers for 3 windows -> o_hi_ber=0, o_ber_count=0, o_win_done pulses every 64 cycles.
2. 16 headers of 2'b11 inside one window -> o_hi_ber=1 one cycle after the 16th; o_ber_count=16.
3. 15 invalid headers in window 1, then 15 in window 2 -> o_hi_ber never asserts; o_ber_count=30.
4. Enter hi_ber, then clean traffic -> o_hi_ber stays 1 through the rest of that window and all of the next; it drops the cycle after the next window's terminal.
5. 10 invalid headers, then i_block_lock low mid-window, then relock -> ST_INIT the next cycle with o_hi_ber=0; 16 fresh invalid headers are needed after relock; o_ber_count keeps 10.
6. 70 invalid headers -> o_ber_count saturates at 63. Then i_ber_cnt_clr together with an invalid header -> o_ber_count=1. Then i_reset_n low while in ST_HI_BER -> all outputs 0 immediately.
